// File: rtl/frame_responder_if.sv
// Byte-stream handshake between a UART rx/tx pair and the frame responder.
// The responder takes the slave side; the UART (or a bench) takes the master side.
interface frame_responder_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] status;
    logic [7:0] err_count;

    modport master (
        output rx_done, rx_data, tx_busy,
        input  tx_start, tx_data, frame_ok, frame_err, status, err_count
    );

    modport slave (
        input  rx_done, rx_data, tx_busy,
        output tx_start, tx_data, frame_ok, frame_err, status, err_count
    );
endinterface

// File: rtl/frame_responder.sv
// Receives MSG_LEN payload bytes plus a CRC-8 byte, checks the CRC and answers with
// ACK + echoed payload + CRC on success, or a single NAK on failure.
module frame_responder #(
    parameter int unsigned MSG_LEN        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    frame_responder_if.slave bus
);

    localparam int unsigned CntW = $clog2(MSG_LEN + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BufW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCheck,
        StTxLoad,
        StTxWaitHi,
        StTxWaitLo
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [7:0]      r_crc;
    logic [7:0]      r_crc_pay;
    logic [TmoW-1:0] r_idle;
    logic [CntW-1:0] r_tx_idx;
    logic            r_ok;
    logic [7:0]      r_tx_data;
    logic [1:0]      r_status;
    logic [7:0]      r_err_count;
    logic [7:0]      r_buf [MSG_LEN];

    logic            w_rx_accept;
    logic [CntW-1:0] w_store_idx;
    logic [7:0]      w_crc_base;
    logic [7:0]      w_crc_next;
    logic            w_crc_ok;
    logic            w_timeout;
    logic            w_last_rx;
    logic            w_last_byte;
    logic            w_load_byte;
    logic            w_err_event;
    logic [CntW-1:0] w_next_idx;
    logic            w_next_ok;
    logic [7:0]      w_next_byte;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    always_comb begin
        w_rx_accept = bus.rx_done && ((r_state == StIdle) || (r_state == StRecv));
        w_store_idx = (r_state == StIdle) ? '0 : r_cnt;
        w_crc_base  = (r_state == StIdle) ? 8'h00 : r_crc;
        w_crc_next  = crc8_step(w_crc_base, bus.rx_data);
        w_crc_ok    = (r_crc == 8'h00);
        w_last_rx   = (r_state == StRecv) && bus.rx_done && (r_cnt == CntW'(MSG_LEN));
        // The idle counter reloads on every byte, so it only runs between bytes.
        w_timeout   = (r_state == StRecv) && !bus.rx_done &&
                      (r_idle == TmoW'(TIMEOUT_CYCLES - 1));
        w_last_byte = (r_tx_idx == (r_ok ? CntW'(MSG_LEN + 1) : '0));
        w_load_byte = (r_state == StCheck) ||
                      ((r_state == StTxWaitLo) && !bus.tx_busy && !w_last_byte);
        w_err_event = ((r_state == StCheck) && !w_crc_ok) || w_timeout;
    end

    // Reply stream: index 0 is ACK/NAK, then the payload, then the payload CRC.
    always_comb begin
        w_next_idx = (r_state == StCheck) ? '0 : r_tx_idx + CntW'(1);
        w_next_ok  = (r_state == StCheck) ? w_crc_ok : r_ok;
        if (w_next_idx == '0) begin
            w_next_byte = w_next_ok ? 8'h06 : 8'h15;
        end else if (w_next_idx == CntW'(MSG_LEN + 1)) begin
            w_next_byte = r_crc_pay;
        end else begin
            w_next_byte = r_buf[BufW'(w_next_idx - CntW'(1))];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (bus.rx_done) w_state_next = StRecv;
            StRecv: begin
                if (w_last_rx) begin
                    w_state_next = StCheck;
                end else if (w_timeout) begin
                    w_state_next = StIdle;
                end
            end
            StCheck:    w_state_next = StTxLoad;
            StTxLoad:   if (!bus.tx_busy) w_state_next = StTxWaitHi;
            StTxWaitHi: if (bus.tx_busy) w_state_next = StTxWaitLo;
            StTxWaitLo: if (!bus.tx_busy) w_state_next = w_last_byte ? StIdle : StTxLoad;
            default:    w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.tx_start  = !i_reset && (r_state == StTxLoad) && !bus.tx_busy;
        bus.frame_ok  = !i_reset && (r_state == StCheck) && w_crc_ok;
        bus.frame_err = !i_reset && w_err_event;
        bus.tx_data   = r_tx_data;
        bus.status    = r_status;
        bus.err_count = r_err_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_crc       <= 8'h00;
            r_crc_pay   <= 8'h00;
            r_idle      <= '0;
            r_tx_idx    <= '0;
            r_ok        <= 1'b0;
            r_tx_data   <= 8'h00;
            r_status    <= 2'b11;
            r_err_count <= 8'h00;
        end else begin
            if (r_state == StIdle) begin
                r_cnt  <= '0;
                r_crc  <= 8'h00;
                r_idle <= '0;
            end
            if (w_rx_accept) begin
                r_crc  <= w_crc_next;
                r_cnt  <= w_store_idx + CntW'(1);
                r_idle <= '0;
                if (w_store_idx == CntW'(MSG_LEN - 1)) begin
                    r_crc_pay <= w_crc_next;
                end
            end else if (r_state == StRecv) begin
                r_idle <= r_idle + TmoW'(1);
            end
            if (r_state == StCheck) begin
                r_ok     <= w_crc_ok;
                r_status <= w_crc_ok ? 2'b01 : 2'b00;
            end
            if (w_timeout) begin
                r_status <= 2'b10;
            end
            if (w_err_event && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_load_byte) begin
                r_tx_idx  <= w_next_idx;
                r_tx_data <= w_next_byte;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rx_accept && (w_store_idx < CntW'(MSG_LEN))) begin
            r_buf[BufW'(w_store_idx)] <= bus.rx_data;
        end
    end

endmodule

// File: doc/frame_responder.md
FRAME_RESPONDER -- requirements
Module: frame_responder

Interface
REQ-001 Parameter MSG_LEN, default 3, SHALL set the number of payload bytes per frame (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the maximum number of clk cycles allowed between received bytes within a frame.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 rx_done  input  1  SHALL be a one-cycle pulse from the UART receiver marking a valid byte.
REQ-006 rx_data  input  8  SHALL carry the received byte and is valid only when rx_done=1.
REQ-007 tx_busy  input  1  SHALL be the UART transmitter busy flag.
REQ-008 tx_start  output  1  SHALL be a one-cycle request to transmit tx_data.
REQ-009 tx_data  output  8  SHALL carry the registered byte to transmit; it is held stable from the tx_start cycle until the end of the byte.
REQ-010 frame_ok  output  1  SHALL pulse for one cycle when a frame passes the CRC check.
REQ-011 frame_err  output  1  SHALL pulse for one cycle on a CRC failure or a timeout abort.
REQ-012 status  output  2  SHALL encode 11=idle/no result, 01=last frame OK, 00=last frame CRC bad, 10=last frame timed out.
REQ-013 err_count  output  8  SHALL count CRC failures plus timeouts and saturate at 0xFF.

Function
REQ-014 Frame format SHALL be MSG_LEN payload bytes followed by 1 CRC byte.
REQ-015 CRC SHALL be CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, computed internally one byte per rx_done.
REQ-016 A frame SHALL pass when the running CRC over all MSG_LEN+1 bytes equals 0x00.
REQ-017 Payload bytes SHALL be stored in an internal MSG_LEN x 8 buffer, indexed by a byte counter.
REQ-018 States SHALL be IDLE, RECV, CHECK, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
REQ-019 IDLE: CRC is cleared to 0x00 and the counter to 0; on rx_done the byte is stored/CRC'd with counter=1, then go to RECV.
REQ-020 RECV: each rx_done stores/CRC's the byte and increments the counter; after byte MSG_LEN+1 go to CHECK.
REQ-021 RECV: an idle counter SHALL reload on every rx_done; if it reaches TIMEOUT_CYCLES, go to IDLE, status=10, pulse frame_err, increment err_count.
REQ-022 CHECK (1 cycle): if CRC==0x00, status=01, pulse frame_ok, and queue reply 0x06, payload[0..MSG_LEN-1], CRC-of-payload (MSG_LEN+2 bytes); otherwise status=00, pulse frame_err, increment err_count, and queue reply 0x15 only.
REQ-023 TX_LOAD: when tx_busy=0, drive tx_start=1 for one cycle with the current reply byte on tx_data, then go to TX_WAIT_HI.
REQ-024 TX_WAIT_HI: wait for tx_busy=1; go to TX_WAIT_LO.
REQ-025 TX_WAIT_LO: on tx_busy=0, advance to the next reply byte and go to TX_LOAD, or go to IDLE after the last byte.
REQ-026 rx_done arriving in CHECK or any TX_* state SHALL be ignored; no buffer or CRC change.
REQ-027 The echoed CRC byte SHALL equal the received CRC byte of a passing frame.
REQ-028 status SHALL hold its value until the next CHECK or timeout, and SHALL NOT return to 11 on entering IDLE.
REQ-029 First-byte latency: tx_start SHALL occur 2 cycles after the rx_done of the CRC byte (CHECK, then TX_LOAD) when tx_busy=0.

Reset
REQ-030 reset=1 SHALL force IDLE and set tx_start=0, tx_data=0x00, frame_ok=0, frame_err=0, status=11, err_count=0x00, counter=0, CRC=0x00.
REQ-031 reset asserted mid-frame or mid-reply SHALL abort immediately; no further tx_start; the partial frame is discarded.

Verification
REQ-032 Rx 4F 4C 41 A6 -> frame_ok pulse, status=01, tx bytes 06 4F 4C 41 A6 in order, err_count=0.
REQ-033 Rx 4F 4C 41 00 -> frame_err pulse, status=00, single tx byte 15, err_count=1.
REQ-034 Rx 4F 4C, then no rx_done for TIMEOUT_CYCLES -> frame_err pulse, status=10, no tx_start, err_count increments; a following 4F 4C 41 A6 passes.
REQ-035 tx_busy held high 3 cycles after each tx_start, with extra rx_done pulses injected during the reply -> one tx_start per byte, never two without tx_busy rise/fall, injected bytes ignored.
REQ-036 Reset pulsed after the 2nd reply byte -> outputs at REQ-030 values, no further tx_start, next good frame replies correctly.
REQ-037 Force 256 bad frames -> err_count saturates at FF.
